half_adder_bist: RTL and testbench

- Synthesizable on-board stimulus generator and checker for the half_adder block: the hardware counterpart of the simulation bench.
- Drives in_1/in_2 from an 8-bit LFSR, waits a settle time, samples the DUT's sum/carry and compares them against the expected values.
- Counts vectors and mismatches, and reports pass/fail so results can be shown on LEDs or a segment display.

---
 rtl/half_adder_bist.sv | 117 +++++++++++
 tb/tb_half_adder_bist.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/half_adder_bist.sv
// On-board stimulus generator and checker for a half_adder: drives LFSR vectors,
// samples sum/carry after a settle time, and counts vectors and mismatches.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start after reset
// ST_LOAD  | seed LFSR, clear counters and result flags, raise busy
// ST_DRIVE | register the next operands onto in_1/in_2
// ST_WAIT  | let the attached adder settle for SETTLE_CYC cycles
// ST_CHECK | compare sum/carry, count, advance LFSR
// ST_DONE  | publish done/pass, wait for the next start
module half_adder_bist #(
   parameter int unsigned NUM_VECTORS = 256,
   parameter int unsigned SETTLE_CYC  = 1,
   parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        start,
   output logic        in_1,
   output logic        in_2,
   input  logic        sum,
   input  logic        carry,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] vec_cnt,
   output logic [15:0] err_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_DRIVE,
      ST_WAIT,
      ST_CHECK,
      ST_DONE
   } state_t;

   // An all-zero LFSR would lock up, so a zero seed is replaced by 8'h01.
   localparam logic [7:0]  SEED_EFF    = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
   localparam logic [15:0] NUM_VEC_W   = 16'(NUM_VECTORS);
   localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYC - 1);

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  lfsr;
   logic [7:0]  lfsr_step;
   logic [7:0]  settle_cnt;
   logic [15:0] vec_nxt;
   logic        mismatch;

   assign lfsr_step = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   assign vec_nxt   = vec_cnt + 16'd1;
   assign mismatch  = {carry, sum} != {in_1 & in_2, in_1 ^ in_2};

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) state <= ST_IDLE;
      else            state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_LOAD;
         ST_LOAD:  state_nxt = ST_DRIVE;
         ST_DRIVE: state_nxt = ST_WAIT;
         ST_WAIT:  if (settle_cnt == SETTLE_LAST) state_nxt = ST_CHECK;
         ST_CHECK: state_nxt = (vec_nxt == NUM_VEC_W) ? ST_DONE : ST_DRIVE;
         ST_DONE:  if (start) state_nxt = ST_LOAD;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         in_1       <= 1'b0;
         in_2       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         vec_cnt    <= 16'd0;
         err_cnt    <= 16'd0;
         lfsr       <= 8'h00;
         settle_cnt <= 8'd0;
      end else begin
         case (state)
            ST_LOAD: begin
               lfsr    <= SEED_EFF;
               vec_cnt <= 16'd0;
               err_cnt <= 16'd0;
               done    <= 1'b0;
               pass    <= 1'b0;
               busy    <= 1'b1;
            end
            ST_DRIVE: begin
               in_1       <= lfsr[0];
               in_2       <= lfsr[1];
               settle_cnt <= 8'd0;
            end
            ST_WAIT: settle_cnt <= settle_cnt + 8'd1;
            ST_CHECK: begin
               if (mismatch && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
               vec_cnt <= vec_nxt;
               lfsr    <= lfsr_step;
            end
            ST_DONE: begin
               busy <= 1'b0;
               done <= 1'b1;
               pass <= (err_cnt == 16'd0);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_half_adder_bist.sv
// Self-checking bench for half_adder_bist: three instances (default run, short
// fault run, back-to-back zero-seed run) each attached to a fault-injectable adder.
module tb_half_adder_bist;

   logic        clk = 1'b0;
   logic [2:0]  rst_n;
   logic [2:0]  start;
   logic [2:0]  in1, in2, sum_w, carry_w, busy, done, pass;
   logic [15:0] vec [3];
   logic [15:0] err [3];
   int          flt [3];

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // fault: 0 none, 1 carry stuck 0, 2 sum stuck 0, 3 sum inverted
   function automatic logic f_sum(input logic a, input logic b, input int f);
      logic [1:0] r;
      r = 2'(int'(a) + int'(b));
      if (f == 2) return 1'b0;
      if (f == 3) return ~r[0];
      return r[0];
   endfunction

   function automatic logic f_carry(input logic a, input logic b, input int f);
      logic [1:0] r;
      r = 2'(int'(a) + int'(b));
      return (f == 1) ? 1'b0 : r[1];
   endfunction

   function automatic int model_errs(input logic [7:0] seed, input int n, input int f);
      logic [7:0] s;
      logic [1:0] good;
      int e;
      e = 0;
      s = (seed == 8'h00) ? 8'h01 : seed;
      for (int i = 0; i < n; i++) begin
         good = 2'(int'(s[0]) + int'(s[1]));
         if ({f_carry(s[0], s[1], f), f_sum(s[0], s[1], f)} != good) e++;
         s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
      end
      return e;
   endfunction

   assign sum_w[0]   = f_sum  (in1[0], in2[0], flt[0]);
   assign carry_w[0] = f_carry(in1[0], in2[0], flt[0]);
   assign sum_w[1]   = f_sum  (in1[1], in2[1], flt[1]);
   assign carry_w[1] = f_carry(in1[1], in2[1], flt[1]);
   assign sum_w[2]   = f_sum  (in1[2], in2[2], flt[2]);
   assign carry_w[2] = f_carry(in1[2], in2[2], flt[2]);

   half_adder_bist dut_a (
      .sys_clk(clk), .sys_rst_n(rst_n[0]), .start(start[0]),
      .in_1(in1[0]), .in_2(in2[0]), .sum(sum_w[0]), .carry(carry_w[0]),
      .busy(busy[0]), .done(done[0]), .pass(pass[0]),
      .vec_cnt(vec[0]), .err_cnt(err[0])
   );

   half_adder_bist #(.NUM_VECTORS(4), .SETTLE_CYC(1), .LFSR_SEED(8'hFF)) dut_b (
      .sys_clk(clk), .sys_rst_n(rst_n[1]), .start(start[1]),
      .in_1(in1[1]), .in_2(in2[1]), .sum(sum_w[1]), .carry(carry_w[1]),
      .busy(busy[1]), .done(done[1]), .pass(pass[1]),
      .vec_cnt(vec[1]), .err_cnt(err[1])
   );

   half_adder_bist #(.NUM_VECTORS(5), .SETTLE_CYC(3), .LFSR_SEED(8'h00)) dut_c (
      .sys_clk(clk), .sys_rst_n(rst_n[2]), .start(start[2]),
      .in_1(in1[2]), .in_2(in2[2]), .sum(sum_w[2]), .carry(carry_w[2]),
      .busy(busy[2]), .done(done[2]), .pass(pass[2]),
      .vec_cnt(vec[2]), .err_cnt(err[2])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulse start on instance k, then watch until done; optionally poke a second
   // start or a 1-cycle reset when vec_cnt reaches poke_at.
   task automatic run_one(input int k, input int poke_at, input bit poke_rst,
                          input int max_cyc, output int bcyc, output bit seen);
      bit poked;
      poked = 1'b0;
      bcyc  = 0;
      seen  = 1'b0;
      @(negedge clk) start[k] = 1'b1;
      @(negedge clk) start[k] = 1'b0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         @(negedge clk);
         start[k] = 1'b0;
         rst_n[k] = 1'b1;
         if (busy[k]) bcyc++;
         if (done[k] && bcyc > 0) seen = 1'b1;
         if (!poked && int'(vec[k]) == poke_at) begin
            poked = 1'b1;
            if (poke_rst) rst_n[k] = 1'b0;
            else          start[k] = 1'b1;
         end
      end
   endtask

   initial begin
      int         bc;
      bit         seen;
      int         exp_e;
      int         gap;
      logic [15:0] v1, e1;
      logic        p1;

      rst_n    = 3'b000;
      start    = 3'b100;
      flt[0]   = 0;
      flt[1]   = 0;
      flt[2]   = 2;

      repeat (5) @(negedge clk);
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_outputs_zero",
               {in1[0], in2[0], busy[0], done[0], pass[0], vec[0], err[0]}, 0);
      end

      // good adder, defaults
      run_one(0, -1, 1'b0, 2000, bc, seen);
      check("dflt_done", seen, 1);
      check("dflt_busy_cycles", bc, 769);
      check("dflt_pass", pass[0], 1);
      check("dflt_vec", vec[0], 256);
      check("dflt_err", err[0], 0);

      // carry stuck at 0, then sum stuck at 0
      flt[1] = 1;
      run_one(1, -1, 1'b0, 100, bc, seen);
      check("carry_flt_done", seen, 1);
      check("carry_flt_busy", bc, 13);
      check("carry_flt_err", err[1], 1);
      check("carry_flt_pass", pass[1], 0);
      check("carry_flt_vec", vec[1], 4);
      flt[1] = 2;
      run_one(1, -1, 1'b0, 100, bc, seen);
      check("sum_flt_done", seen, 1);
      check("sum_flt_err", err[1], 1);
      check("sum_flt_pass", pass[1], 0);
      check("sum_flt_vec", vec[1], 4);

      // second start at vector 10 must be ignored
      flt[0] = 0;
      run_one(0, 10, 1'b0, 2000, bc, seen);
      check("busy_start_done", seen, 1);
      check("busy_start_cycles", bc, 769);
      check("busy_start_vec", vec[0], 256);
      check("busy_start_pass", pass[0], 1);

      // 1-cycle reset at vector 100 aborts with no result
      run_one(0, 100, 1'b1, 1000, bc, seen);
      check("rst_mid_no_done", seen, 0);
      check("rst_mid_outputs_zero",
            {in1[0], in2[0], busy[0], done[0], pass[0], vec[0], err[0]}, 0);

      // randomized fault types and start gaps against the model
      for (int r = 0; r < 4; r++) begin
         flt[0] = int'($urandom_range(0, 3));
         gap    = int'($urandom_range(0, 7));
         repeat (gap) @(negedge clk);
         exp_e  = model_errs(8'hA5, 256, flt[0]);
         run_one(0, -1, 1'b0, 2000, bc, seen);
         check($sformatf("rand%0d_done", r), seen, 1);
         check($sformatf("rand%0d_busy", r), bc, 769);
         check($sformatf("rand%0d_vec", r), vec[0], 256);
         check($sformatf("rand%0d_err", r), err[0], exp_e);
         check($sformatf("rand%0d_pass", r), pass[0], (exp_e == 0) ? 1 : 0);
      end
      for (int r = 0; r < 2; r++) begin
         flt[1] = int'($urandom_range(0, 3));
         exp_e  = model_errs(8'hFF, 4, flt[1]);
         run_one(1, -1, 1'b0, 100, bc, seen);
         check($sformatf("randb%0d_done", r), seen, 1);
         check($sformatf("randb%0d_err", r), err[1], exp_e);
         check($sformatf("randb%0d_pass", r), pass[1], (exp_e == 0) ? 1 : 0);
      end

      // start tied high, seed 0: back-to-back runs
      @(negedge clk) rst_n[2] = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (busy[2]) seen = 1'b1;
      end
      check("b2b_busy_rise", seen, 1);
      @(negedge clk);
      check("b2b_first_vector", {in1[2], in2[2]}, 2'b10);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (done[2]) seen = 1'b1;
      end
      check("b2b_done1", seen, 1);
      v1 = vec[2];
      e1 = err[2];
      p1 = pass[2];
      exp_e = model_errs(8'h00, 5, 2);
      check("b2b_vec1", v1, 5);
      check("b2b_err1", e1, exp_e);
      check("b2b_pass1", p1, (exp_e == 0) ? 1 : 0);
      bc = 0;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         bc++;
         if (i == 0) check("b2b_done_one_cycle", done[2], 0);
         if (done[2]) seen = 1'b1;
      end
      check("b2b_done2", seen, 1);
      check("b2b_period", bc, 27);
      check("b2b_vec_same", vec[2], v1);
      check("b2b_err_same", err[2], e1);
      check("b2b_pass_same", pass[2], p1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
